// File: rtl/dbus_rx_pkg.sv
// Shared definitions for the DBUS receive path.
// Holds state encodings and link-wide defaults that are also used by the transmit side.
package dbus_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_REL   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam int unsigned DBUS_SYNC_DEFAULT    = 2;
  localparam logic [19:0] DBUS_TIMEOUT_DEFAULT = 20'd800000;

endpackage

// File: rtl/dbus_rx_sync_n.sv
// N-deep input synchroniser; resets to 1 so an idle open-drain line reads high.
module dbus_rx_sync_n #(
  parameter int unsigned c_SYNC = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [c_SYNC-1:0] sync_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= i_d;
      for (int unsigned i = 1; i < c_SYNC; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign o_q = sync_q[c_SYNC-1];

endmodule

// File: rtl/dbus_rx.sv
// DBUS two-wire receive engine: acknowledges each bit, assembles bytes LSB-first,
// and offers them through an avail/read handshake with timeout recovery.
module dbus_rx
  import dbus_rx_pkg::*;
#(
  parameter int unsigned             c_SYNC     = DBUS_SYNC_DEFAULT,
  parameter int unsigned             c_TIMEOUTW = 20,
  parameter logic [c_TIMEOUTW-1:0]   c_TIMEOUT  = c_TIMEOUTW'(DBUS_TIMEOUT_DEFAULT)
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_tip,
  input  logic       i_ring,
  output logic       o_tip_drive,
  output logic       o_ring_drive,
  output logic [7:0] o_data,
  output logic       o_avail,
  input  logic       i_read,
  output logic       o_busy,
  output logic       o_error
);

  logic tip_s, ring_s;

  dbus_rx_sync_n #(.c_SYNC(c_SYNC)) u_sync_tip (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_d       (i_tip),
    .o_q       (tip_s)
  );

  dbus_rx_sync_n #(.c_SYNC(c_SYNC)) u_sync_ring (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_d       (i_ring),
    .o_q       (ring_s)
  );

  state_t                  state_q,    state_d;
  logic [2:0]              bitcnt_q,   bitcnt_d;
  logic [7:0]              shift_q,    shift_d;
  logic [c_TIMEOUTW-1:0]   timer_q,    timer_d;
  logic                    bit_q,      bit_d;
  logic [7:0]              data_q,     data_d;
  logic                    avail_q,    avail_d;
  logic                    tip_drv_q,  tip_drv_d;
  logic                    ring_drv_q, ring_drv_d;
  logic                    busy_q,     busy_d;
  logic                    error_q,    error_d;
  logic                    timed_out;

  assign timed_out = (timer_q >= c_TIMEOUT);

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    data_d     = data_q;
    avail_d    = avail_q;
    tip_drv_d  = tip_drv_q;
    ring_drv_d = ring_drv_q;
    error_d    = 1'b0;

    if (i_read && avail_q) begin
      avail_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        tip_drv_d  = 1'b0;
        ring_drv_d = 1'b0;
        if (!tip_s && !ring_s) begin
          state_d = S_ERROR;
        end else if (avail_q && (bitcnt_q == 3'd0)) begin
          // Unread byte pending: leave the sender stalled on its first bit.
          state_d = S_IDLE;
        end else if (!tip_s) begin
          bit_d      = 1'b0;
          ring_drv_d = 1'b1;
          state_d    = S_ACK;
        end else if (!ring_s) begin
          bit_d     = 1'b1;
          tip_drv_d = 1'b1;
          state_d   = S_ACK;
        end else if ((bitcnt_q != 3'd0) && timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_ACK: begin
        if (bit_q ? ring_s : tip_s) begin
          tip_drv_d  = 1'b0;
          ring_drv_d = 1'b0;
          state_d    = S_REL;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_REL: begin
        if (tip_s && ring_s) begin
          shift_d  = {bit_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            data_d  = {bit_q, shift_q[7:1]};
            avail_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        tip_drv_d  = 1'b0;
        ring_drv_d = 1'b0;
        bitcnt_d   = 3'd0;
        if (tip_s && ring_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every path into ERROR funnels through here so the abort cleanup lives in one place.
    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      error_d    = 1'b1;
      tip_drv_d  = 1'b0;
      ring_drv_d = 1'b0;
      bitcnt_d   = 3'd0;
      shift_d    = '0;
    end

    if ((state_d != state_q) || ((state_q == S_IDLE) && (bitcnt_q == 3'd0))) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + c_TIMEOUTW'(1);
    end

    busy_d = (bitcnt_d != 3'd0) || (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      bit_q      <= 1'b0;
      data_q     <= '0;
      avail_q    <= 1'b0;
      tip_drv_q  <= 1'b0;
      ring_drv_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      avail_q    <= avail_d;
      tip_drv_q  <= tip_drv_d;
      ring_drv_q <= ring_drv_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign o_tip_drive  = tip_drv_q;
  assign o_ring_drive = ring_drv_q;
  assign o_data       = data_q;
  assign o_avail      = avail_q;
  assign o_busy       = busy_q;
  assign o_error      = error_q;

endmodule
